// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the on-chip target and the I2C master.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    SUB,
    SUB_ACK,
    WR,
    WR_ACK,
    RD,
    RD_ACK
  } i2c_state_t;

  // R/W bit in the address byte
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// Byte-wide register port of the I2C target.
// master: the I2C target, which issues register accesses.
// slave : the register file answering them.
interface i2c_target_if;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;

  modport master (output reg_addr, output reg_wdata, output reg_we,
                  output reg_re, input reg_rdata);
  modport slave  (input reg_addr, input reg_wdata, input reg_we,
                  input reg_re, output reg_rdata);
endinterface

// File: rtl/i2c_sync_edge.sv
// 2-FF synchronizer for an open-drain pin, followed by a registered edge
// detector. level/rise/fall are all registered and mutually aligned.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;

  // Synchronize, then compare against the previous synchronized level.
  // Idle bus is high, so everything resets to the released state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync  <= {sync[0], pin};
      level <= sync[1];
      rise  <= sync[1] & ~level;
      fall  <= ~sync[1] & level;
    end
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target: decodes START/STOP and bytes on SCL/SDA, ACKs its address,
// loads an 8-bit register pointer and turns data bytes into register port
// writes/reads. Only pulls SDA low for ACKs and zero read bits.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h39
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         scl_in,
  input  logic         sda_in,
  output logic         sda_oe,
  output logic         busy,
  i2c_target_if.master regs
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge u_scl (.clk(clk), .rst_n(rst_n), .pin(scl_in),
                       .level(scl_lvl), .rise(scl_rise), .fall(scl_fall));
  i2c_sync_edge u_sda (.clk(clk), .rst_n(rst_n), .pin(sda_in),
                       .level(sda_lvl), .rise(sda_rise), .fall(sda_fall));

  i2c_state_t state;
  logic [3:0] cnt;
  logic [7:0] shreg;
  logic [7:0] ptr;
  logic [7:0] wdata;
  logic       we, re;
  logic       rd_mode;

  // An SDA edge coincident with an SCL edge is never a bus condition.
  logic no_scl_edge, start_ev, stop_ev;
  logic [7:0] rx_byte;

  assign no_scl_edge = ~scl_rise & ~scl_fall;
  assign start_ev    = sda_fall & scl_lvl & no_scl_edge;
  assign stop_ev     = sda_rise & scl_lvl & no_scl_edge;
  assign rx_byte     = {shreg[6:0], sda_lvl};

  assign regs.reg_addr  = ptr;
  assign regs.reg_wdata = wdata;
  assign regs.reg_we    = we;
  assign regs.reg_re    = re;

  // Bus FSM: bits in on SCL rise, SDA drive changes on SCL fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      shreg   <= 8'h00;
      ptr     <= 8'h00;
      wdata   <= 8'h00;
      we      <= 1'b0;
      re      <= 1'b0;
      rd_mode <= I2C_WRITE;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      we <= 1'b0;
      re <= 1'b0;
      // pointer advances in the cycle after a write strobe
      if (we) ptr <= ptr + 8'd1;
      // read data arrives the cycle after the read strobe
      if (re) shreg <= regs.reg_rdata;

      if (stop_ev) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
      end else if (start_ev) begin
        state  <= ADDR;
        cnt    <= 4'd0;
        sda_oe <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ADDR, SUB, WR: begin
            shreg <= rx_byte;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt <= 4'd0;
              case (state)
                ADDR: begin
                  if (rx_byte[7:1] == DEV_ADDR) begin
                    state   <= ADDR_ACK;
                    busy    <= 1'b1;
                    rd_mode <= rx_byte[0];
                    if (rx_byte[0] == I2C_READ) re <= 1'b1;
                  end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                  end
                end
                SUB: begin
                  ptr   <= rx_byte;
                  state <= SUB_ACK;
                end
                default: begin
                  we    <= 1'b1;
                  wdata <= rx_byte;
                  state <= WR_ACK;
                end
              endcase
            end
          end
          RD: cnt <= cnt + 4'd1;
          RD_ACK: begin
            if (sda_lvl == 1'b0) begin
              ptr <= ptr + 8'd1;
              re  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ADDR_ACK, SUB_ACK, WR_ACK: begin
            // first fall opens the ACK window, second fall closes it
            if (!sda_oe) begin
              sda_oe <= 1'b1;
            end else begin
              sda_oe <= 1'b0;
              cnt    <= 4'd0;
              if (state == ADDR_ACK && rd_mode == I2C_READ) begin
                sda_oe <= ~shreg[7];
                state  <= RD;
              end else if (state == ADDR_ACK) begin
                state <= SUB;
              end else begin
                state <= WR;
              end
            end
          end
          RD: begin
            if (cnt == 4'd8) begin
              sda_oe <= 1'b0;
              state  <= RD_ACK;
            end else begin
              shreg  <= {shreg[6:0], 1'b0};
              sda_oe <= ~shreg[6];
            end
          end
          RD_ACK: begin
            // only reached after an ACK; NACK already left for IDLE
            sda_oe <= ~shreg[7];
            cnt    <= 4'd0;
            state  <= RD;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C master, register model,
// and a scoreboard for register-port strobes.
module tb_i2c_target;

  localparam int Q = 6;  // clk per quarter SCL period (SCL = 24 clk)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;
  logic sda_oe, busy;
  logic scl, sda;

  int tests = 0;
  int fails = 0;

  logic [15:0] wq[$];  // expected {addr, data} of writes
  logic [7:0]  rq[$];  // expected read addresses
  logic [7:0]  mem [256];
  logic        oe_seen, busy_seen;

  always #5 clk = ~clk;

  i2c_target_if rif();

  assign scl = m_scl;
  assign sda = m_sda & ~sda_oe;
  assign rif.reg_rdata = mem[rif.reg_addr];

  i2c_target dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl), .sda_in(sda),
    .sda_oe(sda_oe), .busy(busy), .regs(rif)
  );

  // Strobe monitor: pop the scoreboard on every register access.
  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (rst_n && rif.reg_we) begin
      tests++;
      assert (wq.size() != 0) else begin
        fails++;
        $error("FAIL we_unexpected got=%h/%h want=none", rif.reg_addr, rif.reg_wdata);
      end
      if (wq.size() != 0) begin
        logic [15:0] e;
        e = wq.pop_front();
        tests++;
        assert ({rif.reg_addr, rif.reg_wdata} === e) else begin
          fails++;
          $error("FAIL we_data got=%h want=%h", {rif.reg_addr, rif.reg_wdata}, e);
        end
      end
    end
    if (rst_n && rif.reg_re) begin
      tests++;
      assert (rq.size() != 0) else begin
        fails++;
        $error("FAIL re_unexpected got=%h want=none", rif.reg_addr);
      end
      if (rq.size() != 0) begin
        logic [7:0] ea;
        ea = rq.pop_front();
        tests++;
        assert (rif.reg_addr === ea) else begin
          fails++;
          $error("FAIL re_addr got=%h want=%h", rif.reg_addr, ea);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // One SCL pulse with master driving b; returns bus level mid-high.
  task automatic clk_bit(input logic b, output logic s);
    m_sda = b;
    wait_clk(Q); m_scl = 1'b1;
    wait_clk(Q); s = sda;
    wait_clk(Q); m_scl = 1'b0;
    wait_clk(Q);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_clk(Q);
    m_scl = 1'b1; wait_clk(Q);
    m_sda = 1'b1; wait_clk(2*Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
    clk_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(nack, s);
    m_sda = 1'b1;
  endtask

  initial begin
    logic ack, s;
    logic [7:0] rd;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h3C;
    oe_seen = 1'b0;
    busy_seen = 1'b0;

    // reset values
    wait_clk(3);
    chk("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
    chk("rst_we_re", {14'd0, rif.reg_we, rif.reg_re}, 16'd0);
    chk("rst_addr_wdata", {rif.reg_addr, rif.reg_wdata}, 16'h0000);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // single write 0x1A = 0x5C
    wq.push_back(16'h1A5C);
    i2c_start();
    write_byte(8'h72, ack); chk("wr_addr_ack", {15'd0, ack}, 16'd1);
    chk("wr_busy", {15'd0, busy}, 16'd1);
    write_byte(8'h1A, ack); chk("wr_sub_ack", {15'd0, ack}, 16'd1);
    write_byte(8'h5C, ack); chk("wr_data_ack", {15'd0, ack}, 16'd1);
    i2c_stop();
    chk("wr_busy_stop", {15'd0, busy}, 16'd0);
    chk("wr_drained", 16'(wq.size()), 16'd0);

    // burst with pointer wrap
    wq.push_back(16'hFE11); wq.push_back(16'hFF22); wq.push_back(16'h0033);
    i2c_start();
    write_byte(8'h72, ack); chk("bw_addr_ack", {15'd0, ack}, 16'd1);
    write_byte(8'hFE, ack); chk("bw_sub_ack", {15'd0, ack}, 16'd1);
    write_byte(8'h11, ack); chk("bw_d0_ack", {15'd0, ack}, 16'd1);
    write_byte(8'h22, ack); chk("bw_d1_ack", {15'd0, ack}, 16'd1);
    write_byte(8'h33, ack); chk("bw_d2_ack", {15'd0, ack}, 16'd1);
    i2c_stop();
    chk("bw_drained", 16'(wq.size()), 16'd0);

    // combined read with repeated START
    i2c_start();
    write_byte(8'h72, ack); chk("rd_waddr_ack", {15'd0, ack}, 16'd1);
    write_byte(8'h10, ack); chk("rd_sub_ack", {15'd0, ack}, 16'd1);
    i2c_start();
    rq.push_back(8'h10);
    write_byte(8'h73, ack); chk("rd_raddr_ack", {15'd0, ack}, 16'd1);
    rq.push_back(8'h11);
    read_byte(1'b0, rd); chk("rd_byte0", {8'h00, rd}, 16'h00A5);
    read_byte(1'b1, rd); chk("rd_byte1", {8'h00, rd}, 16'h003C);
    chk("rd_idle_busy", {15'd0, busy}, 16'd0);
    chk("rd_released", {15'd0, sda_oe}, 16'd0);
    i2c_stop();
    chk("rd_drained", 16'(rq.size()), 16'd0);

    // address mismatch: bus ignored
    oe_seen = 1'b0; busy_seen = 1'b0;
    i2c_start();
    write_byte(8'h50, ack); chk("mm_nack", {15'd0, ack}, 16'd0);
    write_byte(8'h00, ack); chk("mm_data_nack", {15'd0, ack}, 16'd0);
    i2c_stop();
    chk("mm_oe_never", {15'd0, oe_seen}, 16'd0);
    chk("mm_busy_never", {15'd0, busy_seen}, 16'd0);

    // reset during bit 4 of a data byte
    i2c_start();
    write_byte(8'h72, ack); chk("ab_addr_ack", {15'd0, ack}, 16'd1);
    write_byte(8'h20, ack); chk("ab_sub_ack", {15'd0, ack}, 16'd1);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s);
    m_sda = 1'b0; wait_clk(Q); m_scl = 1'b1; wait_clk(Q/2);
    rst_n = 1'b0;
    #1;
    chk("ab_oe_async", {15'd0, sda_oe}, 16'd0);
    chk("ab_busy_async", {15'd0, busy}, 16'd0);
    wait_clk(3);
    rst_n = 1'b1;
    m_scl = 1'b0; wait_clk(Q);
    m_sda = 1'b1; wait_clk(Q);
    m_scl = 1'b1; wait_clk(2*Q);
    wq.push_back(16'h0277);
    i2c_start();
    write_byte(8'h72, ack); chk("ab2_addr_ack", {15'd0, ack}, 16'd1);
    write_byte(8'h02, ack); chk("ab2_sub_ack", {15'd0, ack}, 16'd1);
    write_byte(8'h77, ack); chk("ab2_data_ack", {15'd0, ack}, 16'd1);
    i2c_stop();
    chk("ab2_drained", 16'(wq.size()), 16'd0);

    // STOP after three data bits
    i2c_start();
    write_byte(8'h72, ack); chk("es_addr_ack", {15'd0, ack}, 16'd1);
    write_byte(8'h20, ack); chk("es_sub_ack", {15'd0, ack}, 16'd1);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s);
    chk("es_busy_mid", {15'd0, busy}, 16'd1);
    i2c_stop();
    chk("es_busy", {15'd0, busy}, 16'd0);
    chk("es_oe", {15'd0, sda_oe}, 16'd0);

    wait_clk(8);
    chk("end_wq", 16'(wq.size()), 16'd0);
    chk("end_rq", 16'(rq.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (responder) that answers the transfers issued by the design's I2C master and exposes them as a byte-wide register port. It lets the master and the HDMI configuration sequence be exercised on-chip and in simulation without the external HDMI transmitter. It also gives the GameBoy core a small, master-writable control/status register window. It samples open-drain SCL/SDA pins in the system clock domain and pulls SDA low only for ACKs and read data.

## Interface
- DEV_ADDR, 7'h39, 7-bit target address; this matches the HDMI transmitter so the master's configuration stream is accepted unmodified.
- clk  in  1  system clock; one clock; must be at least 16× the SCL frequency.
- rst_n  in  1  reset, asynchronous and active-low.
- scl_in  in  1  raw SCL pin level (asynchronous).
- sda_in  in  1  raw SDA pin level (asynchronous).
- sda_oe  out  1  1 = drive SDA low; 0 = release. The pad ties SDA to 0 when sda_oe = 1.
- reg_addr  out  8  register pointer for the current access.
- reg_wdata  out  8  write byte; valid while reg_we = 1.
- reg_we  out  1  one-cycle write strobe.
- reg_re  out  1  one-cycle read strobe.
- reg_rdata  in  8  read byte; the user returns it the cycle after reg_re and the block samples it then.
- busy  out  1  1 from an address match until STOP, or until return to IDLE.

## Operation
- Each pin passes through a 2-FF synchronizer plus an edge-detect register. There is no glitch filter.
- Bus events:
  - START = SDA fall while SCL high.
  - STOP = SDA rise while SCL high.
  - Data bits are sampled on SCL rise; sda_oe changes only after SCL fall.
- FSM states: IDLE, ADDR, ADDR_ACK, SUB, SUB_ACK, WR, WR_ACK, RD, RD_ACK.
- START from any state → ADDR, with bit count cleared. This covers repeated START.
- STOP from any state → IDLE, sda_oe = 0, busy = 0.
- ADDR: shift 8 bits MSB first.
  - Upper 7 bits ≠ DEV_ADDR → IDLE (bus ignored until the next START).
  - Match → ADDR_ACK, busy = 1.
- ADDR_ACK: drive ACK for one SCL pulse.
  - R/W = 0 → SUB.
  - R/W = 1 → pulse reg_re with the current pointer, latch reg_rdata, then RD.
- SUB: 8 bits load the pointer → SUB_ACK (ACK) → WR.
- WR: 8 bits → pulse reg_we with reg_addr = pointer and reg_wdata = byte → WR_ACK (ACK).
  - Pointer increments after the strobe.
  - Next state is WR.
- RD: shift the latched byte out MSB first. Bit 7 is driven after the SCL fall that ends the previous ACK. A 1 bit releases SDA.
- RD_ACK: release SDA and sample the master's bit on SCL rise.
  - ACK (0) → pointer increments, reg_re pulses, byte latched, back to RD.
  - NACK (1) → IDLE.
- The pointer is 8-bit and wraps 8'hFF → 8'h00. It persists across transactions (a read without SUB continues from the last pointer). Reset sets it to 0.
- This target never stretches SCL.

## Timing
- Reset values: sda_oe 0, reg_we 0, reg_re 0, reg_addr 8'h00, reg_wdata 8'h00, busy 0, state IDLE.
- Detection latency: a pin edge is recognised 3 clk after it occurs.
- sda_oe update: 1 clk after the detected SCL fall (4 clk after the pin edge). It is held through the following SCL high phase.
- ACK window: sda_oe = 1 from the SCL fall after bit 8 until the SCL fall after the 9th pulse.
- reg_we: asserted 1 clk, 1 clk after the SCL rise that samples bit 8 of a data byte.
- reg_re: asserted 1 clk. reg_rdata is sampled on the next clk, which is always before the SCL fall that begins the byte.
- Simultaneous events: SDA and SCL edges detected in the same clk are not a START or STOP. The SCL edge is processed and the SDA level is taken from the synchronized value.
- rst_n asserted mid-transfer: all outputs go to reset values asynchronously and SDA is released. After reset release the block waits in IDLE for a START.

## Structure
- Package i2c_pkg holds:
  - typedef enum i2c_state_t (the nine states);
  - constants I2C_WRITE = 1'b0 and I2C_READ = 1'b1.
- The master is to share i2c_pkg.
- Sub-module i2c_sync_edge: 2-FF synchronizer plus edge detect, with outputs level, rise and fall. It is instantiated twice (SCL and SDA).
- Top-level FSM, bit counter, shift register and pointer live in i2c_target.

## Test plan
- Write: START, 0x72, 0x1A, 0x5C, STOP → three ACKs; reg_we once with reg_addr 0x1A and reg_wdata 0x5C; busy falls at STOP.
- Burst with wrap: START, 0x72, 0xFE, 0x11, 0x22, 0x33, STOP → writes 0xFE=0x11, 0xFF=0x22, 0x00=0x33.
- Combined read: START, 0x72, 0x10, repeated START, 0x73; model returns 0xA5 then 0x3C; master ACK then NACK → bus shows 0xA5 then 0x3C; two reg_re pulses at addresses 0x10 and 0x11; IDLE after the NACK.
- Address mismatch: START, 0x50, 0x00, STOP → sda_oe stays 0 throughout; no reg_we; busy stays 0.
- Abort: assert rst_n = 0 during bit 4 of a data byte → sda_oe = 0 immediately and no reg_we. After release, a fresh write to 0x02 = 0x77 is accepted.
- Early STOP: START, 0x72, 0x20, then 3 data bits, then STOP → no reg_we; IDLE; busy = 0.
